// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Request/result handshake bundle for the nibble-serial add/subtract controller.
interface nibble_serial_addsub_ctrl_if #(
  parameter int unsigned NIBBLES = 2
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// Runs a W-bit add/subtract through an external 4-bit adder, one nibble per
// cycle LSB first, with the inter-nibble carry held in a register.
module nibble_serial_addsub_ctrl #(
  parameter int unsigned NIBBLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  nibble_serial_addsub_ctrl_if.slave   bus,
  output logic [3:0]                   add_a,
  output logic [3:0]                   add_b,
  output logic                         add_cin,
  input  logic [3:0]                   add_sum,
  input  logic                         add_cout
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_d;
  logic [IW-1:0]  idx, idx_d;
  logic [W-1:0]   a_r, a_d;
  logic [W-1:0]   b_r, b_d;
  logic           c_r, c_d;
  logic [W-1:0]   res_r, res_d;
  logic           load;

  // Next-state, datapath update and adder drive
  always_comb begin
    state_d = state;
    idx_d   = idx;
    a_d     = a_r;
    b_d     = b_r;
    c_d     = c_r;
    res_d   = res_r;
    load    = 1'b0;
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b ^ {W{bus.sub}};
          c_d     = bus.sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a                = a_r[4*idx +: 4];
        add_b                = b_r[4*idx +: 4];
        add_cin              = c_r;
        res_d[4*idx +: 4]    = add_sum;
        c_d                  = add_cout;
        if (idx == IW'(NIBBLES - 1)) begin
          idx_d   = '0;
          load    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx + IW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      a_r           <= '0;
      b_r           <= '0;
      c_r           <= 1'b0;
      res_r         <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.zero      <= 1'b0;
    end else begin
      state         <= state_d;
      idx           <= idx_d;
      a_r           <= a_d;
      b_r           <= b_d;
      c_r           <= c_d;
      res_r         <= res_d;
      bus.in_ready  <= (state_d == IDLE);
      bus.out_valid <= (state_d == DONE);
      if (load) begin
        bus.result    <= res_d;
        bus.carry_out <= add_cout;
        // b_r already holds ~B for subtract, so one rule covers both ops
        bus.overflow  <= (a_r[W-1] == b_r[W-1]) && (add_sum[3] != a_r[W-1]);
        bus.zero      <= (res_d == '0);
      end
    end
  end
endmodule
